// File: rtl/sync_debounce.sv
// Synchroniser + stability-counter debouncer producing a clean level and rise/fall pulses.
// Optional push-on/push-off toggle output enabled by defining SYNC_DEBOUNCE_TOGGLE_EN.
module sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 4,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef SYNC_DEBOUNCE_TOGGLE_EN
  ,
  output logic toggle
`endif
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   q_d, rise_d, fall_d;

  assign s = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], d_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      q       <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q       <= q_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // An opposing sample in a WAIT state takes priority over reaching the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        q_d = 1'b0;
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        q_d = 1'b1;
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase
  end

  assign busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);

`ifdef SYNC_DEBOUNCE_TOGGLE_EN
  // Flips on the same edge that raises rise, so both change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle <= 1'b0;
    end else begin
      toggle <= toggle ^ rise_d;
    end
  end
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: a run-length reference model pushes expected
// outputs per edge, which are popped and compared after the edge.
module tb_sync_debounce;

  localparam int SS = 2;
  localparam int SC = 4;

  logic clk;
  logic rst_n;
  logic d_in;
  logic q, rise, fall, busy;
`ifdef SYNC_DEBOUNCE_TOGGLE_EN
  logic toggle;
`endif

  sync_debounce #(.SYNC_STAGES(SS), .STABLE_CNT(SC), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (d_in),
    .q     (q),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
`ifdef SYNC_DEBOUNCE_TOGGLE_EN
    ,
    .toggle(toggle)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #100 clk = ~clk;
  end

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
    logic busy;
    logic toggle;
  } exp_t;

  exp_t  sb[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  string phase        = "init";

  bit    m_sync[SS];
  bit    m_q, m_rise, m_fall, m_busy, m_toggle;
  int    m_run;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got %0h, want %0h at %0t", phase, tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < SS; i++) m_sync[i] = 1'b0;
    m_q = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_toggle = 0; m_run = 0;
    sb.delete();
  endtask

  // Reference: q flips once the synchronised input has disagreed with q on SC consecutive edges.
  task automatic modelStep(input bit d);
    bit   s;
    exp_t e;
    s = m_sync[SS-1];
    for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = d;
    m_rise = 0;
    m_fall = 0;
    m_run  = (s != m_q) ? m_run + 1 : 0;
    if (m_run == SC) begin
      m_q   = ~m_q;
      m_run = 0;
      if (m_q) begin
        m_rise   = 1;
        m_toggle = ~m_toggle;
      end else begin
        m_fall = 1;
      end
    end
    m_busy = (m_run != 0);
    e = '{q: m_q, rise: m_rise, fall: m_fall, busy: m_busy, toggle: m_toggle};
    sb.push_back(e);
  endtask

  task automatic popCompare();
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      checkOutput("q", q, e.q);
      checkOutput("rise", rise, e.rise);
      checkOutput("fall", fall, e.fall);
      checkOutput("busy", busy, e.busy);
`ifdef SYNC_DEBOUNCE_TOGGLE_EN
      checkOutput("toggle", toggle, e.toggle);
`endif
    end
  endtask

  // Drive on the falling edge, predict, then compare just after the rising edge.
  task automatic applyStimulus(input logic d);
    @(negedge clk);
    d_in = d;
    modelStep(d);
    @(posedge clk);
    #1;
    popCompare();
  endtask

  // Called at posedge+1: asserts reset mid-cycle, checks immediate clearing, releases before negedge.
  task automatic resetMidCycle(input logic d_level);
    #49;
    rst_n = 1'b0;
    d_in  = d_level;
    #1;
    checkOutput("rst_q", q, 0);
    checkOutput("rst_rise", rise, 0);
    checkOutput("rst_fall", fall, 0);
    checkOutput("rst_busy", busy, 0);
`ifdef SYNC_DEBOUNCE_TOGGLE_EN
    checkOutput("rst_toggle", toggle, 0);
`endif
    modelReset();
    #24;
    rst_n = 1'b1;
  endtask

  task automatic idleLow(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  initial begin
    int   first_rise;
    int   rise_count;
    bit   rise_seen;
    logic bounce [10];

    rst_n = 1'b0;
    d_in  = 1'b0;
    modelReset();
    phase = "reset_init";
    #50;
    checkOutput("q", q, 0);
    checkOutput("rise", rise, 0);
    checkOutput("fall", fall, 0);
    checkOutput("busy", busy, 0);
    #100;
    rst_n = 1'b1;
    idleLow(3);

    phase = "reset_mid";
    applyStimulus(1'b0);
    resetMidCycle(1'b0);

    phase = "clean_rise";
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1);
      checkOutput("lat_busy", busy, (i >= 2 && i < 5));
      checkOutput("lat_q", q, (i >= 5));
      checkOutput("lat_rise", rise, (i == 5));
    end

    phase = "clean_fall";
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0);
      checkOutput("lat_q", q, (i < 5));
      checkOutput("lat_fall", fall, (i == 5));
    end

    phase = "glitch";
    rise_seen = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i < 2 ? 1'b1 : 1'b0);
      if (rise || q) rise_seen = 1;
    end
    checkOutput("no_rise", rise_seen, 0);
    checkOutput("busy_end", busy, 0);

    phase = "bounce";
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    first_rise = -1;
    rise_count = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(bounce[i]);
      if (rise) begin
        rise_count++;
        if (first_rise < 0) first_rise = i;
      end
    end
    checkOutput("rise_count", rise_count, 1);
    checkOutput("rise_edge", first_rise, 7);
    idleLow(10);

    phase = "reset_wait";
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    checkOutput("busy_before", busy, 1);
    resetMidCycle(1'b1);
    first_rise = -1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1);
      if (rise && first_rise < 0) first_rise = i;
    end
    checkOutput("rise_edge", first_rise, 5);
    checkOutput("q_final", q, 1);
    idleLow(10);

`ifdef SYNC_DEBOUNCE_TOGGLE_EN
    phase = "toggle";
    resetMidCycle(1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) applyStimulus(1'b1);
      checkOutput("after_press", toggle, (p % 2 == 0));
      for (int i = 0; i < 8; i++) applyStimulus(1'b0);
      checkOutput("after_release", toggle, (p % 2 == 0));
    end
`endif

    checkOutput("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
